// File: rtl/urv_divide_iter.sv
// Iterative 32-bit RISC-V DIV/DIVU/REM/REMU unit: one restoring step per cycle.
// Divide-by-zero and signed overflow can optionally bypass the iteration.
module urv_divide_iter #(
    parameter bit g_early_exit = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        start_i,
    input  logic [31:0] d_rs1_i,
    input  logic [31:0] d_rs2_i,
    input  logic [2:0]  d_fun_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] w_rd_o
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_busy;
    logic           r_done;
    logic           w_busy_nxt;
    logic           w_done_nxt;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2:0]     r_fun;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_d;
    logic [W-1:0]   r_rem;
    logic [CW-1:0]  r_cnt;
    logic           r_qsign;
    logic           r_rsign;
    logic [W-1:0]   r_rd;

    logic           w_accept;
    logic           w_signed;
    logic           w_is_rem;
    logic           w_valid_op;
    logic           w_div0;
    logic           w_ovf;
    logic           w_special;
    logic           w_early;
    logic [W-1:0]   w_special_res;
    logic [W-1:0]   w_fix_res;
    logic [W:0]     w_shift;
    logic [W+1:0]   w_sub;
    logic           w_borrow;

    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                        start_i && !x_stall_i && !x_kill_i;
    assign w_signed   = !r_fun[0];
    assign w_is_rem   = r_fun[1];
    assign w_valid_op = r_fun[2];

    // r_a / r_b keep the raw operands for the whole operation, so the
    // corner-case flags stay valid from PREP through FIX.
    assign w_div0    = (r_b == '0);
    assign w_ovf     = w_signed && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    assign w_special = w_valid_op && (w_div0 || w_ovf);
    assign w_early   = g_early_exit && w_special;

    always_comb begin
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = w_is_rem ? r_a : '1;
        end else begin
            w_special_res = w_is_rem ? '0 : 32'h8000_0000;
        end
    end

    always_comb begin
        w_fix_res = '0;
        if (!w_valid_op) begin
            w_fix_res = '0;
        end else if (w_special) begin
            w_fix_res = w_special_res;
        end else if (w_is_rem) begin
            w_fix_res = r_rsign ? W'(-r_rem) : r_rem;
        end else begin
            w_fix_res = r_qsign ? W'(-r_q) : r_q;
        end
    end

    // Restoring step: shift next dividend bit into the partial remainder.
    assign w_shift  = {r_rem, r_q[W-1]};
    assign w_sub    = {1'b0, w_shift} - {2'b00, r_d};
    assign w_borrow = w_sub[W+1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        if (x_kill_i) begin
            w_next = S_IDLE;
        end else if (!x_stall_i) begin
            case (r_state)
                S_IDLE:  if (start_i) w_next = S_PREP;
                S_PREP:  w_next = w_early ? S_DONE : S_DIV;
                S_DIV:   if (r_cnt == '0) w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = start_i ? S_PREP : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_next)
            S_PREP, S_DIV, S_FIX: w_busy_nxt = 1'b1;
            S_DONE:               w_done_nxt = 1'b1;
            default:              ;
        endcase
    end

    // Datapath is frozen by stall and by kill (kill leaves w_rd_o untouched).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_fun   <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_rd    <= '0;
        end else if (!x_kill_i && !x_stall_i) begin
            if (w_accept) begin
                r_a   <= d_rs1_i;
                r_b   <= d_rs2_i;
                r_fun <= d_fun_i;
            end
            case (r_state)
                S_PREP: begin
                    r_q     <= (w_signed && r_a[W-1]) ? W'(-r_a) : r_a;
                    r_d     <= (w_signed && r_b[W-1]) ? W'(-r_b) : r_b;
                    r_rem   <= '0;
                    r_cnt   <= CW'(W - 1);
                    r_qsign <= w_signed && (r_a[W-1] ^ r_b[W-1]);
                    r_rsign <= w_signed && r_a[W-1];
                    if (w_early) begin
                        r_rd <= w_special_res;
                    end
                end
                S_DIV: begin
                    r_q   <= {r_q[W-2:0], !w_borrow};
                    r_rem <= w_borrow ? w_shift[W-1:0] : w_sub[W-1:0];
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    r_rd <= w_fix_res;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign w_rd_o = r_rd;

endmodule

// File: tb/tb_urv_divide_iter.sv
// Scoreboard bench for urv_divide_iter: early-exit and full-path instances
// share stimulus; each has its own expected-result queue and monitor.
module tb_urv_divide_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        kill = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [2:0]  fun = '0;

    logic        busy1, done1, busy0, done0;
    logic [31:0] rd1, rd0;

    urv_divide_iter #(.g_early_exit(1'b1)) u_dut_ee1 (
        .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(stall), .x_kill_i(kill),
        .start_i(start), .d_rs1_i(rs1), .d_rs2_i(rs2), .d_fun_i(fun),
        .busy_o(busy1), .done_o(done1), .w_rd_o(rd1)
    );

    urv_divide_iter #(.g_early_exit(1'b0)) u_dut_ee0 (
        .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(stall), .x_kill_i(kill),
        .start_i(start), .d_rs1_i(rs1), .d_rs2_i(rs2), .d_fun_i(fun),
        .busy_o(busy0), .done_o(done0), .w_rd_o(rd0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          sp;
        string       name;
    } vec_t;

    exp_t q1[$];
    exp_t q0[$];
    vec_t vecs[$];

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor for the early-exit instance.
    logic pd1 = 1'b0;
    exp_t e1;
    always @(negedge clk) begin
        if (done1 && !pd1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done_ee1 got w_rd_o=%h exp no done", rd1);
            end else begin
                e1 = q1.pop_front();
                check32({e1.name, "_ee1_rd"}, rd1, e1.res);
                check32({e1.name, "_ee1_cyc"}, 32'(cyc), 32'(e1.due));
            end
        end
        pd1 = done1;
    end

    // Monitor for the full-path instance.
    logic pd0 = 1'b0;
    exp_t e0;
    always @(negedge clk) begin
        if (done0 && !pd0) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done_ee0 got w_rd_o=%h exp no done", rd0);
            end else begin
                e0 = q0.pop_front();
                check32({e0.name, "_ee0_rd"}, rd0, e0.res);
                check32({e0.name, "_ee0_cyc"}, 32'(cyc), 32'(e0.due));
            end
        end
        pd0 = done0;
    end

    // Drive a start for one edge; must be called away from a rising edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input bit sp, input bit push,
                         input int extra, input string nm);
        fun   = f;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        if (push) begin
            q1.push_back('{res: r, due: cyc + 1 + (sp ? 1 : 34) + extra, name: nm});
            q0.push_back('{res: r, due: cyc + 1 + 34 + extra, name: nm});
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 150) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 150) begin
            failures++;
            $display("FAIL %s_timeout got pending=%0d exp 0", nm, q1.size() + q0.size());
            q1.delete();
            q0.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done1) begin
            failures++;
            $display("FAIL %s_done_timeout got done_o=0 exp 1", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{3'b101, 32'd100,        32'd7,          32'd14,         1'b0, "divu_100_7"});
        vecs.push_back('{3'b111, 32'd100,        32'd7,          32'd2,          1'b0, "remu_100_7"});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, "div_m7_2"});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, "rem_m7_2"});
        vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, "rem_7_m2"});
        vecs.push_back('{3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, "div_m100_m7"});
        vecs.push_back('{3'b110, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0, "rem_m100_7"});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, "divu_max_1"});
        vecs.push_back('{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, "divu_big"});
        vecs.push_back('{3'b001, 32'd100,        32'd7,          32'd0,          1'b0, "noop"});
        vecs.push_back('{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, "div_5_0"});
        vecs.push_back('{3'b110, 32'd5,          32'd0,          32'd5,          1'b1, "rem_5_0"});
        vecs.push_back('{3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1, "rem_m5_0"});
        vecs.push_back('{3'b100, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1, "div_m5_0"});
        vecs.push_back('{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, "divu_5_0"});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "div_ovf"});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, "rem_ovf"});

        // Reset state.
        #12;
        check32("rst_busy", {31'd0, busy1}, 32'd0);
        check32("rst_done", {31'd0, done1}, 32'd0);
        check32("rst_rd", rd1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].sp, 1'b1, 0, vecs[i].name);
            wait_idle(vecs[i].name);
        end

        // Mid-DIV stall of 10 cycles, with an ignored start while busy.
        issue(3'b101, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b1, 10, "stall_divu");
        repeat (5) @(posedge clk);
        #1;
        fun = 3'b101; rs1 = 32'd1; rs2 = 32'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 stall = 1'b1;
        repeat (10) @(posedge clk);
        #1 stall = 1'b0;

        // Stall while in DONE keeps done_o asserted.
        wait_done("stall_done");
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check32("stall_done_hold_ee1", {31'd0, done1}, 32'd1);
            check32("stall_done_hold_ee0", {31'd0, done0}, 32'd1);
            check32("stall_done_rd", rd1, 32'd100);
        end
        stall = 1'b0;
        @(negedge clk);
        check32("stall_release_done", {31'd0, done1}, 32'd0);
        wait_idle("stall_divu");

        // Kill mid-operation: busy drops, no done, result untouched.
        issue(3'b101, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 0, "kill_divu");
        repeat (14) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check32("kill_busy_ee1", {31'd0, busy1}, 32'd0);
        check32("kill_busy_ee0", {31'd0, busy0}, 32'd0);
        check32("kill_rd", rd1, 32'd100);
        repeat (45) @(negedge clk);
        issue(3'b101, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1, 0, "after_kill_divu");
        wait_idle("after_kill_divu");

        // Asynchronous reset mid-DIV.
        issue(3'b101, 32'd1000, 32'd10, 32'd0, 1'b0, 1'b0, 0, "reset_divu");
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check32("async_rst_busy_ee1", {31'd0, busy1}, 32'd0);
        check32("async_rst_busy_ee0", {31'd0, busy0}, 32'd0);
        check32("async_rst_rd", rd1, 32'd0);
        check32("async_rst_done", {31'd0, done1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, 0, "post_rst_divu");
        wait_idle("post_rst_divu");

        // Back-to-back: second start accepted while first result is in DONE.
        issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, 0, "b2b_first");
        wait_done("b2b_first");
        issue(3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1, 0, "b2b_second");
        wait_idle("b2b_second");

        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            failures++;
            $display("FAIL final_queue got pending=%0d exp 0", q1.size() + q0.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
